// File: rtl/level_peak_hold_pkg.sv
// Shared audio meter definitions: default widths, FSM encoding, full-scale helper.
package level_peak_hold_pkg;

    // Defaults shared with section_min_max and the level meter.
    localparam int          DEFAULT_WIDTH      = 16;
    localparam int          DEFAULT_HOLD_COUNT = 8;
    localparam int unsigned DEFAULT_DECAY_STEP = 32'h0000_0200;

    // Meter FSM: accept a pair, compute the new level, present it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } meter_state_e;

    // Magnitude at or above which a section is flagged as clipping:
    // the largest positive two's-complement value, 2^(w-1) - 1.
    function automatic int unsigned full_scale(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/level_peak_hold_signed_abs.sv
// Combinational absolute value of a two's-complement word. The result is
// unsigned and one code wider in range, so the most negative input maps to
// 2^(width-1) without wrapping.
module signed_abs
    import level_peak_hold_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic [width-1:0] value_i,
    output logic [width-1:0] mag_o
);

    // Negate negative inputs; the unsigned reinterpretation keeps -2^(w-1) exact.
    always_comb begin
        mag_o = value_i[width-1] ? (~value_i + 1'b1) : value_i;
    end

endmodule

// File: rtl/level_peak_hold.sv
// Peak-hold level meter: takes a section min/max pair, converts it to a
// magnitude, and tracks a level that jumps up to new peaks, holds for a
// number of sections, then decays linearly without undershooting the
// current section's magnitude.
module level_peak_hold
    import level_peak_hold_pkg::*;
#(
    parameter int          width      = DEFAULT_WIDTH,
    parameter int          hold_count = DEFAULT_HOLD_COUNT,
    parameter int unsigned decay_step = DEFAULT_DECAY_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_min_value,
    input  logic [width-1:0] i_max_value,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_level,
    output logic             o_clip
);

    // hold_count + 2 keeps the counter at least one bit wide when hold_count is 0.
    localparam int               HCW         = $clog2(hold_count + 2);
    localparam logic [HCW-1:0]   HOLD_LOAD   = HCW'(hold_count);
    localparam logic [width-1:0] DECAY       = width'(decay_step);
    localparam logic [width-1:0] CLIP_THRESH = width'(full_scale(width));

    meter_state_e     state_q, state_d;
    logic [width-1:0] min_q, min_d;
    logic [width-1:0] max_q, max_d;
    logic [width-1:0] level_q, level_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic [width-1:0] o_level_q, o_level_d;
    logic             o_clip_q, o_clip_d;

    logic [width-1:0] abs_min;
    logic [width-1:0] abs_max;
    logic [width-1:0] mag;
    logic [width-1:0] decayed;

    signed_abs #(.width(width)) u_abs_min (
        .value_i (min_q),
        .mag_o   (abs_min)
    );

    signed_abs #(.width(width)) u_abs_max (
        .value_i (max_q),
        .mag_o   (abs_max)
    );

    // Section magnitude and the decayed level, floored at zero and at mag.
    always_comb begin
        mag     = (abs_min >= abs_max) ? abs_min : abs_max;
        decayed = (level_q > DECAY) ? (level_q - DECAY) : '0;
        if (decayed < mag) begin
            decayed = mag;
        end
    end

    // Next-state, capture and level update logic.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        level_d   = level_q;
        hold_d    = hold_q;
        o_level_d = o_level_q;
        o_clip_d  = o_clip_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    min_d   = i_min_value;
                    max_d   = i_max_value;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (mag >= level_q) begin
                    level_d = mag;
                    hold_d  = HOLD_LOAD;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    level_d = decayed;
                end
                o_level_d = level_d;
                o_clip_d  = (mag >= CLIP_THRESH);
                state_d   = ST_OUT;
            end
            ST_OUT: begin
                if (o_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset overrides any handshake in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            min_q     <= '0;
            max_q     <= '0;
            level_q   <= '0;
            hold_q    <= '0;
            o_level_q <= '0;
            o_clip_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            level_q   <= level_d;
            hold_q    <= hold_d;
            o_level_q <= o_level_d;
            o_clip_q  <= o_clip_d;
        end
    end

    // Handshake and output drive.
    always_comb begin
        i_ready = (state_q == ST_IDLE) && !reset;
        o_valid = (state_q == ST_OUT);
        o_level = o_level_q;
        o_clip  = o_clip_q;
    end

endmodule

// File: tb/tb_level_peak_hold.sv
// Directed bench for level_peak_hold: a vector table for the level/hold/decay
// behaviour plus hand sequences for backpressure and reset during CALC.
module tb_level_peak_hold;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_min_value;
    logic [15:0] i_max_value;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_level;
    logic        o_clip;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;

    typedef struct {
        logic        rst_before;
        logic [15:0] mn;
        logic [15:0] mx;
        logic [15:0] lvl;
        logic        clp;
    } vec_t;

    vec_t vecs[$];

    level_peak_hold dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_min_value (i_min_value),
        .i_max_value (i_max_value),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_level     (o_level),
        .o_clip      (o_clip)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_valid && o_ready) begin
            xfer_cnt <= xfer_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [15:0] mn, input logic [15:0] mx,
                       input logic [15:0] lvl, input logic clp);
        vec_t v;
        v.rst_before = r;
        v.mn         = mn;
        v.mx         = mx;
        v.lvl        = lvl;
        v.clp        = clp;
        vecs.push_back(v);
    endtask

    // Called at a negedge; leaves at a negedge one cycle after reset release.
    task automatic do_reset();
        reset   = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        check("reset_i_ready", {31'd0, i_ready}, 32'd0);
        check("reset_o_valid", {31'd0, o_valid}, 32'd0);
        check("reset_o_level", {16'd0, o_level}, 32'd0);
        check("reset_o_clip",  {31'd0, o_clip},  32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_i_ready", {31'd0, i_ready}, 32'd1);
    endtask

    // Called at a negedge; presents a pair, checks 2-cycle latency and result.
    task automatic apply(input logic [15:0] mn, input logic [15:0] mx,
                         input logic [15:0] lvl, input logic clp, input string tag);
        int guard = 0;
        i_min_value = mn;
        i_max_value = mx;
        i_valid     = 1'b1;
        while (!i_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_accept_wait"}, {31'd0, (guard < 20)}, 32'd1);
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        check({tag, "_o_valid_c1"}, {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_o_valid_c2"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_level"}, {16'd0, o_level}, {16'd0, lvl});
        check({tag, "_clip"},  {31'd0, o_clip},  {31'd0, clp});
        $display("txn %s min=%h max=%h level=%h clip=%0d", tag, mn, mx, o_level, o_clip);
    endtask

    initial begin
        int base;
        reset       = 1'b1;
        i_valid     = 1'b0;
        i_min_value = '0;
        i_max_value = '0;
        o_ready     = 1'b1;

        // First section after reset.
        add(1, 16'hEEEE, 16'h1111, 16'h1112, 0);
        // Peak, 8 held sections, then linear decay.
        add(0, 16'h0000, 16'h4000, 16'h4000, 0);
        for (int k = 0; k < 8; k++) add(0, 16'h0000, 16'h0000, 16'h4000, 0);
        add(0, 16'h0000, 16'h0000, 16'h3E00, 0);
        add(0, 16'h0000, 16'h0000, 16'h3C00, 0);
        // Decay saturates at zero.
        add(1, 16'h0000, 16'h0300, 16'h0300, 0);
        for (int k = 0; k < 8; k++) add(0, 16'h0000, 16'h0000, 16'h0300, 0);
        add(0, 16'h0000, 16'h0000, 16'h0100, 0);
        add(0, 16'h0000, 16'h0000, 16'h0000, 0);
        // Most negative input and positive full scale both clip.
        add(0, 16'h8000, 16'h0000, 16'h8000, 1);
        add(0, 16'h0000, 16'h7FFF, 16'h8000, 1);
        for (int k = 0; k < 7; k++) add(0, 16'h0000, 16'h0000, 16'h8000, 0);
        // Decay is floored by the current magnitude.
        add(0, 16'h0000, 16'h7F00, 16'h7F00, 0);
        add(0, 16'h0000, 16'h0000, 16'h7D00, 0);
        // Equal magnitude counts as a new peak; one below full scale is not a clip.
        add(0, 16'h8300, 16'h0000, 16'h7D00, 0);
        add(0, 16'h0000, 16'h7FFE, 16'h7FFE, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            apply(vecs[i].mn, vecs[i].mx, vecs[i].lvl, vecs[i].clp, $sformatf("vec%0d", i));
        end

        // Backpressure: output held for 5 cycles, then a single transfer.
        @(negedge clk);
        do_reset();
        o_ready     = 1'b0;
        i_min_value = 16'h0000;
        i_max_value = 16'h1000;
        i_valid     = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        base = xfer_cnt;
        check("bp_o_valid", {31'd0, o_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_o_valid", c), {31'd0, o_valid}, 32'd1);
            check($sformatf("bp_hold%0d_level", c), {16'd0, o_level}, 32'h1000);
            check($sformatf("bp_hold%0d_i_ready", c), {31'd0, i_ready}, 32'd0);
        end
        o_ready = 1'b1;
        @(negedge clk);
        check("bp_one_xfer", xfer_cnt - base, 32'd1);
        check("bp_release_o_valid", {31'd0, o_valid}, 32'd0);
        check("bp_release_i_ready", {31'd0, i_ready}, 32'd1);
        @(negedge clk);
        check("bp_no_extra_xfer", xfer_cnt - base, 32'd1);
        $display("txn backpressure level=1000 transfers=%0d", xfer_cnt - base);

        // Reset while in CALC discards the pending output and the level.
        i_min_value = 16'h0000;
        i_max_value = 16'h2000;
        i_valid     = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        base  = xfer_cnt;
        @(negedge clk);
        check("rc_i_ready_in_reset", {31'd0, i_ready}, 32'd0);
        check("rc_o_valid", {31'd0, o_valid}, 32'd0);
        check("rc_o_level", {16'd0, o_level}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rc_idle%0d_o_valid", c), {31'd0, o_valid}, 32'd0);
        end
        check("rc_no_xfer", xfer_cnt - base, 32'd0);
        $display("txn reset_in_calc discarded");
        apply(16'h0000, 16'h0050, 16'h0050, 1'b0, "rc_first");

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/level_peak_hold.md
LEVEL_PEAK_HOLD -- requirements
Module: level_peak_hold

Interface
REQ-001 Parameter width, default 16: bit width of the signed min/max inputs and of the unsigned level output.
REQ-002 Parameter hold_count, default 8: number of sections the peak is held before decay starts.
REQ-003 Parameter decay_step, default 16'h0200: amount subtracted from the level per section during decay.
REQ-004 Port clk  in  1: single clock; all state changes on its rising edge.
REQ-005 Port reset  in  1: synchronous, active-high reset.
REQ-006 Port i_valid  in  1: i_min_value/i_max_value pair presented.
REQ-007 Port i_ready  out  1: block accepts a pair this cycle.
REQ-008 Port i_min_value  in  width: section minimum, two's complement.
REQ-009 Port i_max_value  in  width: section maximum, two's complement.
REQ-010 Port o_valid  out  1: o_level/o_clip valid.
REQ-011 Port o_ready  in  1: downstream accepts the output.
REQ-012 Port o_level  out  width: unsigned meter level, 0..2^(width-1).
REQ-013 Port o_clip  out  1: section reached full scale.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, CALC, OUT.
REQ-015 i_ready SHALL be 1 only in IDLE; an input is accepted when i_valid & i_ready at a rising edge, which moves the FSM to CALC and registers both inputs.
REQ-016 In CALC the block SHALL compute mag = max(abs(min), abs(max)), with abs(-2^(width-1)) = 2^(width-1) and no overflow, then update state and move to OUT.
REQ-017 Update rule: if mag >= level, then level = mag and hold_cnt = hold_count.
REQ-018 Otherwise, if hold_cnt > 0, then hold_cnt decrements and level is unchanged.
REQ-019 Otherwise, level = max(level - decay_step saturated at 0, mag); the level never goes below 0 and never drops below the current mag.
REQ-020 o_clip SHALL be 1 for this output when mag >= 2^(width-1) - 1, else 0.
REQ-021 In OUT, o_valid SHALL be 1 and o_level/o_clip stable; when o_valid & o_ready the FSM returns to IDLE.
REQ-022 Accept-to-o_valid latency SHALL be exactly 2 cycles; with o_ready held at 1 the throughput is one pair per 3 cycles.
REQ-023 While o_ready is 0 in OUT, the block SHALL hold its outputs indefinitely and keep i_ready at 0 (backpressure).
REQ-024 hold_count = 0 SHALL mean decay starts in the first section after a new peak.

Reset
REQ-025 With reset = 1 at a rising edge: FSM to IDLE; level, hold_cnt, o_level, o_clip to 0; o_valid to 0.
REQ-026 Reset SHALL take priority over any handshake in the same cycle, including mid-CALC or mid-OUT; the pending output is discarded.
REQ-027 i_ready SHALL be 0 while reset is asserted.

Structure
REQ-028 The FSM state encoding and the full-scale constant SHALL live in the shared audio meter package, alongside the width defaults used by section_min_max.
REQ-029 One sub-module, signed_abs (width-parameterised, combinational, saturation-free absolute value), SHALL be instantiated twice.

Verification
REQ-030 After reset, min=16'hEEEE, max=16'h1111 -> o_level=16'h1112 and o_clip=0, 2 cycles after accept.
REQ-031 Peak 16'h4000, then 8 sections of 0/0 -> o_level stays 16'h4000; the 9th gives 16'h3E00 and the 10th gives 16'h3C00.
REQ-032 Decayed level 16'h0100 with mag 0 -> o_level=0 (saturation at zero).
REQ-033 min=16'h8000 -> o_level=16'h8000 and o_clip=1; next section max=16'h7FFF -> o_clip=1.
REQ-034 Hold o_ready=0 for 5 cycles in OUT -> o_level stable and i_ready=0 throughout; a single transfer follows on release.
REQ-035 Assert reset in CALC -> no o_valid, o_level=0, and the next input is treated as the first after reset.
